clock_set_ctrl: RTL
===================

Name: clock_set_ctrl

Overview:
Front-panel control stage that sits directly upstream of the BCD digital clock. It debounces three push-buttons and runs a field-edit FSM for hours, minutes and seconds. It drives the clock's hh_in/mm_in/ss_in buses with a one-cycle load or put_alarm pulse. It also generates the clock's 1 Hz ena tick, which is suppressed while the running time is being edited.

Parameters:
TICK_DIV, 100000000, clk cycles per ena pulse (≥2)
DEB_CYCLES, 1000000, cycles a synchronised button level must stay stable before it is accepted (≥1)
TIMEOUT_TICKS, 10, ena-period intervals with no accepted press before an edit aborts (≥1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
btn_mode  in  1  raw async button; enter edit / advance field
btn_inc  in  1  raw async button; increment current field
sel_alarm  in  1  level; 0 = edit clock time, 1 = edit alarm time; sampled on edit entry
cur_hh  in  8  running hours, BCD, from clock
cur_mm  in  8  running minutes, BCD
cur_ss  in  8  running seconds, BCD
hh_in  out  8  edit buffer hours, BCD
mm_in  out  8  edit buffer minutes, BCD
ss_in  out  8  edit buffer seconds, BCD
load  out  1  one-cycle pulse: commit buffer to clock
put_alarm  out  1  one-cycle pulse: commit buffer as alarm
ena  out  1  one-cycle tick every TICK_DIV cycles
editing  out  1  high in SET_HH/SET_MM/SET_SS
edit_field  out  2  0 = none, 1 = hh, 2 = mm, 3 = ss

Behaviour:
- Reset: state IDLE. All outputs 0. Buffers 8'h00. Prescaler 0. Debouncers' stable level 0. Latched target 0.
- Debounce:
  - Each raw button passes a 2-flop synchroniser.
  - The stable level updates after the synchronised level differs from it for DEB_CYCLES consecutive cycles.
  - A 0→1 stable transition gives a one-cycle press pulse.
  - Raw edge to press pulse is 2+DEB_CYCLES cycles. A glitch shorter than DEB_CYCLES produces no pulse.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - ena=1 in the cycle count==TICK_DIV-1, except when editing=1 and latched target = clock, where ena=0 (counter keeps running).
  - On a clock-target COMMIT the counter clears to 0, so the first post-load ena comes TICK_DIV cycles later.
- FSM states: IDLE, SET_HH, SET_MM, SET_SS, COMMIT.
  - IDLE on mode press → SET_HH. Buffers ← cur_hh/mm/ss and target ← sel_alarm in the same edge. Inc presses are ignored in IDLE.
  - SET_HH → SET_MM → SET_SS on mode press. SET_SS → COMMIT on mode press.
  - COMMIT lasts exactly one cycle, then → IDLE. It asserts load (target 0) or put_alarm (target 1), never both. Buffers are stable during and after COMMIT.
  - Inc press in SET_x increments that field in BCD:
    - hh wraps 23→00; mm/ss wrap 59→00.
    - Low digit 9→0 carries into the high digit.
  - Mode and inc pressed in the same cycle: the increment applies to the current field and the state advances on the same edge.
  - Timeout: a counter counts ena-period wraps (prescaler wraps, regardless of masking) while editing. It clears on every accepted press. At TIMEOUT_TICKS the FSM → IDLE with no load/put_alarm, and the buffers hold their value.
  - Reset mid-edit: the FSM returns to IDLE next edge with no commit pulse.
- sel_alarm changes after edit entry are ignored until the next entry.
- hh_in/mm_in/ss_in are always driven from the buffers, which only change on entry, inc or reset.

Decomposition:
- Shared package clock_pkg:
  - FSM state encoding constants (IDLE=0 … COMMIT=4, 3 bits).
  - Field codes 0–3.
  - BCD limit constants: HH_MAX=8'h23, MS_MAX=8'h59.
- One sub-module btn_debounce (param DEB_CYCLES; ports clk, reset, raw, level, press), instantiated twice.
- BCD increment-with-limit is a function, not a module.

Test Plan:
- Debounce, with DEB_CYCLES=4: btn_inc raw high for 3 cycles → no press. Raw high for 10 cycles → exactly one press pulse, 6 cycles after the raw edge.
- Set clock, with TICK_DIV=8, cur=12:34:56, sel_alarm=0:
  - mode → SET_HH with hh_in=8'h12; ena stays 0.
  - inc ×12 in SET_HH → hh_in=8'h00 (wrap at 23).
  - mode ×3 → single load pulse with buffer 00:34:56; first ena exactly 8 cycles later.
- Minute wrap and carry: in SET_MM from 8'h58, inc ×2 → 8'h59 then 8'h00. From 8'h09, inc → 8'h10.
- Alarm commit: with sel_alarm=1, enter edit, toggle sel_alarm to 0, then mode ×4 → put_alarm pulse, load stays 0, and ena keeps pulsing every TICK_DIV cycles during the edit.
- Timeout: with TIMEOUT_TICKS=3, enter SET_MM and leave the buttons idle → IDLE after the 3rd prescaler wrap, with no load/put_alarm.
- Simultaneous press and reset:
  - Mode and inc press on the same cycle in SET_SS from 8'h07 → ss_in=8'h08 and the FSM in COMMIT.
  - Reset asserted in SET_MM → IDLE next edge, all outputs 0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the front-panel clock-set controller: FSM states, edit field
// codes and the BCD wrap limits.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET_HH = 3'd1,
        ST_SET_MM = 3'd2,
        ST_SET_SS = 3'd3,
        ST_COMMIT = 3'd4
    } state_e;

    localparam logic [1:0] FLD_NONE = 2'd0;
    localparam logic [1:0] FLD_HH   = 2'd1;
    localparam logic [1:0] FLD_MM   = 2'd2;
    localparam logic [1:0] FLD_SS   = 2'd3;

    localparam logic [7:0] HH_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

    // Increments a packed BCD value. It wraps to 00 at lim and carries 9 into the tens digit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] lim);
        logic [7:0] res;
        if (val == lim) begin
            res = 8'h00;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability filter. The filter emits a one-cycle
// press pulse when the accepted level rises.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned   CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // The counter reaching zero marks the DEB_CYCLES-th consecutive differing cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= CNT_LOAD;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= CNT_LOAD;
            end else if (cnt_q == '0) begin
                level_q <= sync2_q;
                press_q <= sync2_q;
                cnt_q   <= CNT_LOAD;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Front-panel time/alarm editor for the BCD clock. It debounces the buttons, edits
// hh:mm:ss, commits the result with load/put_alarm and generates the 1 Hz ena tick.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 100000000,
    parameter int unsigned DEB_CYCLES    = 1000000,
    parameter int unsigned TIMEOUT_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sel_alarm,
    input  logic [7:0] cur_hh,
    input  logic [7:0] cur_mm,
    input  logic [7:0] cur_ss,
    output logic [7:0] hh_in,
    output logic [7:0] mm_in,
    output logic [7:0] ss_in,
    output logic       load,
    output logic       put_alarm,
    output logic       ena,
    output logic       editing,
    output logic [1:0] edit_field
);

    localparam int unsigned   PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam int unsigned   TW       = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);

    logic          mode_press;
    logic          inc_press;
    logic          mode_lvl_unused;
    logic          inc_lvl_unused;
    logic          pre_wrap;

    state_e        state_q;
    logic          target_q;
    logic [7:0]    hh_q;
    logic [7:0]    mm_q;
    logic [7:0]    ss_q;
    logic          load_q;
    logic          put_q;
    logic          editing_q;
    logic [1:0]    field_q;
    logic [TW-1:0] to_q;
    logic [PW-1:0] pre_q;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_mode),
        .level (mode_lvl_unused),
        .press (mode_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_inc),
        .level (inc_lvl_unused),
        .press (inc_press)
    );

    assign pre_wrap = (pre_q == PRE_LAST);

    // Restarting the prescaler after a clock load aligns the seconds to the moment of commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else if ((state_q == ST_COMMIT) && !target_q) begin
            pre_q <= '0;
        end else if (pre_wrap) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            target_q  <= 1'b0;
            hh_q      <= 8'h00;
            mm_q      <= 8'h00;
            ss_q      <= 8'h00;
            load_q    <= 1'b0;
            put_q     <= 1'b0;
            editing_q <= 1'b0;
            field_q   <= FLD_NONE;
            to_q      <= '0;
        end else begin
            load_q <= 1'b0;
            put_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mode_press) begin
                        state_q   <= ST_SET_HH;
                        hh_q      <= cur_hh;
                        mm_q      <= cur_mm;
                        ss_q      <= cur_ss;
                        target_q  <= sel_alarm;
                        to_q      <= '0;
                        editing_q <= 1'b1;
                        field_q   <= FLD_HH;
                    end
                end
                ST_SET_HH, ST_SET_MM, ST_SET_SS: begin
                    if (inc_press) begin
                        case (state_q)
                            ST_SET_HH: hh_q <= bcd_inc(hh_q, HH_MAX);
                            ST_SET_MM: mm_q <= bcd_inc(mm_q, MS_MAX);
                            default:   ss_q <= bcd_inc(ss_q, MS_MAX);
                        endcase
                    end
                    if (mode_press || inc_press) begin
                        to_q <= '0;
                    end else if (pre_wrap) begin
                        to_q <= to_q + 1'b1;
                    end
                    // A mode press that arrives with an inc press still advances after the increment.
                    if (mode_press) begin
                        case (state_q)
                            ST_SET_HH: begin
                                state_q <= ST_SET_MM;
                                field_q <= FLD_MM;
                            end
                            ST_SET_MM: begin
                                state_q <= ST_SET_SS;
                                field_q <= FLD_SS;
                            end
                            default: begin
                                state_q   <= ST_COMMIT;
                                editing_q <= 1'b0;
                                field_q   <= FLD_NONE;
                                load_q    <= ~target_q;
                                put_q     <= target_q;
                            end
                        endcase
                    end else if (!inc_press && pre_wrap && (to_q == TO_LAST)) begin
                        state_q   <= ST_IDLE;
                        editing_q <= 1'b0;
                        field_q   <= FLD_NONE;
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    editing_q <= 1'b0;
                    field_q   <= FLD_NONE;
                end
            endcase
        end
    end

    assign hh_in      = hh_q;
    assign mm_in      = mm_q;
    assign ss_in      = ss_q;
    assign load       = load_q;
    assign put_alarm  = put_q;
    assign editing    = editing_q;
    assign edit_field = field_q;
    assign ena        = pre_wrap & ~(editing_q & ~target_q);

endmodule
